// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - byte-stream intake and instruction-memory write bus of the program loader
// master: the loader side (accepts bytes, drives memory writes); slave: upstream source / memory side.
interface prog_loader_if;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        inst_we;
  logic [31:0] inst_wr_addr;
  logic [31:0] inst_wr_data;

  modport master (
    input  byte_valid, byte_data,
    output byte_ready, inst_we, inst_wr_addr, inst_wr_data
  );

  modport slave (
    output byte_valid, byte_data,
    input  byte_ready, inst_we, inst_wr_addr, inst_wr_data
  );
endinterface

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - loads a length-prefixed little-endian word stream into instruction memory
// Optional trailing 32-bit checksum when LOADER_CHECKSUM_EN is defined.
module prog_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 1024
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  prog_loader_if.master bus,
  output logic          core_reset,
  output logic          busy,
  output logic          done,
  output logic          error
);

  localparam logic [31:0] MAX_W = 32'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_WRITE,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  byte_cnt;
  logic [31:0] word_cnt;
  logic [31:0] n_words;
  logic [23:0] asm_word;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic        rdy;
  logic        hs;
  logic        last_byte;
  logic        start_take;
  logic [31:0] full_word;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] csum_acc;
`endif

  assign rdy        = (state == S_HDR) || (state == S_DATA) || (state == S_CSUM);
  assign hs         = bus.byte_valid && rdy;
  assign last_byte  = hs && (byte_cnt == 2'd3);
  assign start_take = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
  // The fourth byte is combined live so header/checksum decisions happen on its handshake.
  assign full_word  = {bus.byte_data, asm_word};

  always_comb begin
    state_nxt        = state;
    bus.byte_ready   = rdy;
    bus.inst_we      = 1'b0;
    bus.inst_wr_addr = addr_q;
    bus.inst_wr_data = data_q;
    core_reset       = 1'b1;
    busy             = 1'b0;
    done             = 1'b0;
    error            = 1'b0;

    case (state)
      S_IDLE: begin
        if (start_take) state_nxt = S_HDR;
      end
      S_HDR: begin
        busy = 1'b1;
        if (last_byte) begin
          if ((full_word == 32'd0) || (full_word > MAX_W)) state_nxt = S_ERR;
          else                                             state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        busy = 1'b1;
        if (last_byte) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        busy        = 1'b1;
        bus.inst_we = 1'b1;
        if (word_cnt + 32'd1 == n_words) begin
`ifdef LOADER_CHECKSUM_EN
          state_nxt = S_CSUM;
`else
          state_nxt = S_DONE;
`endif
        end else begin
          state_nxt = S_DATA;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        busy = 1'b1;
        if (last_byte) begin
          if (full_word == csum_acc) state_nxt = S_DONE;
          else                       state_nxt = S_ERR;
        end
      end
`endif
      S_DONE: begin
        done       = 1'b1;
        core_reset = 1'b0;
        if (start_take) state_nxt = S_HDR;
      end
      S_ERR: begin
        error = 1'b1;
        if (start_take) state_nxt = S_HDR;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      byte_cnt <= 2'd0;
      word_cnt <= 32'd0;
      n_words  <= 32'd0;
      asm_word <= 24'd0;
      addr_q   <= BASE_ADDR;
      data_q   <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
      csum_acc <= 32'd0;
`endif
    end else begin
      state <= state_nxt;

      if (start_take) begin
        byte_cnt <= 2'd0;
        word_cnt <= 32'd0;
        addr_q   <= BASE_ADDR;
`ifdef LOADER_CHECKSUM_EN
        csum_acc <= 32'd0;
`endif
      end

      if (hs) begin
        byte_cnt <= byte_cnt + 2'd1;
        if (state == S_DATA) begin
          data_q[{byte_cnt, 3'b000} +: 8] <= bus.byte_data;
        end else begin
          case (byte_cnt)
            2'd0:    asm_word[7:0]   <= bus.byte_data;
            2'd1:    asm_word[15:8]  <= bus.byte_data;
            2'd2:    asm_word[23:16] <= bus.byte_data;
            default: asm_word        <= asm_word;
          endcase
        end
        if ((state == S_HDR) && (byte_cnt == 2'd3)) begin
          n_words <= full_word;
`ifdef LOADER_CHECKSUM_EN
          csum_acc <= full_word;
`endif
        end
      end

      if (state == S_WRITE) begin
        addr_q   <= addr_q + 32'd4;
        word_cnt <= word_cnt + 32'd1;
`ifdef LOADER_CHECKSUM_EN
        csum_acc <= csum_acc + data_q;
`endif
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - randomized self-checking bench for prog_loader (two instances, two base addresses)
module tb_prog_loader;
  localparam logic [31:0] BASE_B = 32'hFFFF_FFFC;
  localparam int          MAXW   = 1024;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       tvalid = 1'b0;
  logic [7:0] tdata = 8'd0;

  logic cr_a, busy_a, done_a, err_a;
  logic cr_b, busy_b, done_b, err_b;

  always #5 clk = ~clk;

  prog_loader_if ifa ();
  prog_loader_if ifb ();

  assign ifa.byte_valid = tvalid;
  assign ifa.byte_data  = tdata;
  assign ifb.byte_valid = tvalid;
  assign ifb.byte_data  = tdata;

  prog_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(MAXW)) dut_a (
    .clk(clk), .reset(reset), .start(start), .bus(ifa),
    .core_reset(cr_a), .busy(busy_a), .done(done_a), .error(err_a)
  );

  prog_loader #(.BASE_ADDR(BASE_B), .MAX_WORDS(MAXW)) dut_b (
    .clk(clk), .reset(reset), .start(start), .bus(ifb),
    .core_reset(cr_b), .busy(busy_b), .done(done_b), .error(err_b)
  );

  int n_pass = 0;
  int n_total = 0;
  int k = 0;
  int consumed = 0;
  int sent = 0;
  int gap_pct = 0;
  bit alt_mode = 0;
  bit alt_phase = 0;
  bit stray_start = 0;
  logic [31:0] stim_words[$];
  logic [31:0] exp_words[$];
  logic [31:0] obs_a_addr[$];
  logic [31:0] obs_a_data[$];
  logic [31:0] obs_b_addr[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Per-cycle rules and the write scoreboard; sampled after drivers settle on the falling edge.
  always @(negedge clk) begin
    #1;
    if (!reset) begin
      chk("ready_rule", {31'd0, ifa.byte_ready}, {31'd0, busy_a & ~ifa.inst_we});
      chk("core_reset_rule", {31'd0, cr_a}, {31'd0, ~done_a});
      chk("b_core_reset_rule", {31'd0, cr_b}, {31'd0, ~done_b});
      chk("status_excl", {31'd0, $countones({busy_a, done_a, err_a}) <= 1}, 32'd1);
      if (tvalid && ifa.byte_ready) consumed++;
      if (ifa.inst_we || ifb.inst_we) begin
        chk("we_a", {31'd0, ifa.inst_we}, 32'd1);
        chk("we_b", {31'd0, ifb.inst_we}, 32'd1);
        if (k < exp_words.size()) begin
          chk("wr_data_a", ifa.inst_wr_data, exp_words[k]);
          chk("wr_data_b", ifb.inst_wr_data, exp_words[k]);
          chk("wr_addr_a", ifa.inst_wr_addr, 32'(4 * k));
          chk("wr_addr_b", ifb.inst_wr_addr, BASE_B + 32'(4 * k));
        end else begin
          n_total++;
          $display("FAIL extra_write: got write #%0d expected only %0d writes", k, exp_words.size());
        end
        obs_a_addr.push_back(ifa.inst_wr_addr);
        obs_a_data.push_back(ifa.inst_wr_data);
        obs_b_addr.push_back(ifb.inst_wr_addr);
        k++;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int  guard;
    bit  ok;
    guard = 0;
    ok = 0;
    while (!ok && guard < 2000) begin
      @(negedge clk);
      guard++;
      start = stray_start && busy_a && ($urandom_range(0, 99) < 5);
      if (alt_mode) alt_phase = !alt_phase;
      if ((alt_mode && alt_phase) || (!alt_mode && ($urandom_range(0, 99) < gap_pct))) begin
        tvalid = 1'b0;
        tdata  = 8'($urandom);
      end else begin
        tvalid = 1'b1;
        tdata  = b;
        if (ifa.byte_ready) begin
          @(posedge clk);
          ok = 1;
        end
      end
    end
    sent++;
    if (!ok) chk("byte_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic run_session(input logic [31:0] n, input bit csum_bad);
    bit          bad;
    bit          exp_err;
    logic [31:0] sum;
    int          guard;
    bad = (n == 32'd0) || (n > 32'(MAXW));
    exp_words.delete();
    if (!bad) foreach (stim_words[i]) exp_words.push_back(stim_words[i]);
    exp_err = bad;
`ifdef LOADER_CHECKSUM_EN
    if (!bad && csum_bad) exp_err = 1;
`endif
    sum = n;
    foreach (stim_words[i]) sum = sum + stim_words[i];
    k = 0;
    consumed = 0;
    sent = 0;
    obs_a_addr.delete();
    obs_a_data.delete();
    obs_b_addr.delete();

    @(negedge clk);
    tvalid = 1'b0;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", {31'd0, busy_a}, 32'd1);
    chk("start_core_reset", {31'd0, cr_a}, 32'd1);

    send_word(n);
    if (!bad) begin
      foreach (stim_words[i]) send_word(stim_words[i]);
`ifdef LOADER_CHECKSUM_EN
      send_word(csum_bad ? sum + 32'(1 + $urandom_range(0, 1000)) : sum);
`endif
    end

    guard = 0;
    do begin
      @(negedge clk);
      start  = 1'b0;
      tvalid = 1'($urandom_range(0, 1));
      tdata  = 8'($urandom);
      guard++;
    end while (!(done_a || err_a) && guard < 50);
    if (guard >= 50) chk("end_timeout", 32'd0, 32'd1);
    #2;
    chk("end_done", {31'd0, done_a}, {31'd0, !exp_err});
    chk("end_error", {31'd0, err_a}, {31'd0, exp_err});
    chk("end_core_reset", {31'd0, cr_a}, {31'd0, exp_err});
    chk("end_b_done", {31'd0, done_b}, {31'd0, !exp_err});
    chk("write_count", 32'(k), 32'(exp_words.size()));
    chk("bytes_consumed", 32'(consumed), 32'(sent));
  endtask

  task automatic pin_req035;
    if (obs_a_addr.size() >= 2) begin
      chk("p_addr0", obs_a_addr[0], 32'h0000_0000);
      chk("p_data0", obs_a_data[0], 32'h0050_0013);
      chk("p_addr1", obs_a_addr[1], 32'h0000_0004);
      chk("p_data1", obs_a_data[1], 32'h0010_0093);
      chk("p_b_addr0", obs_b_addr[0], 32'hFFFF_FFFC);
      chk("p_b_addr1", obs_b_addr[1], 32'h0000_0000);
    end else begin
      chk("p_write_count", 32'(obs_a_addr.size()), 32'd2);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, {31'd0, busy_a}, 32'd0);
    chk({tag, "_done"}, {31'd0, done_a}, 32'd0);
    chk({tag, "_error"}, {31'd0, err_a}, 32'd0);
    chk({tag, "_core_reset"}, {31'd0, cr_a}, 32'd1);
    chk({tag, "_ready"}, {31'd0, ifa.byte_ready}, 32'd0);
    chk({tag, "_we"}, {31'd0, ifa.inst_we}, 32'd0);
    chk({tag, "_addr_a"}, ifa.inst_wr_addr, 32'h0000_0000);
    chk({tag, "_addr_b"}, ifb.inst_wr_addr, BASE_B);
    chk({tag, "_data"}, ifa.inst_wr_data, 32'h0000_0000);
  endtask

  initial begin
    logic [31:0] n;
    #12;
    check_reset_outputs("rst");
    @(negedge clk);
    reset = 1'b0;
    tvalid = 1'b1;
    tdata  = 8'hA5;
    repeat (3) @(negedge clk);
    #2;
    chk("idle_ready", {31'd0, ifa.byte_ready}, 32'd0);
    chk("idle_core_reset", {31'd0, cr_a}, 32'd1);

    // Directed two-word load, back-to-back then with every-other-cycle valid.
    stim_words = '{32'h0050_0013, 32'h0010_0093};
    run_session(32'd2, 1'b0);
    pin_req035();
    alt_mode = 1;
    run_session(32'd2, 1'b0);
    pin_req035();
    alt_mode = 0;
`ifdef LOADER_CHECKSUM_EN
    run_session(32'd2, 1'b1);
`endif

    // Header rejection and length boundaries.
    stim_words.delete();
    run_session(32'd0, 1'b0);
    run_session(32'd1025, 1'b0);
    run_session(32'hFFFF_FFFF, 1'b0);
    stim_words = '{32'hDEAD_BEEF};
    run_session(32'd1, 1'b0);
    stim_words.delete();
    for (int i = 0; i < MAXW; i++) stim_words.push_back($urandom);
    run_session(32'(MAXW), 1'b0);

    // Reset mid-session after six accepted bytes, then a fresh one-word load.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_word(32'd3);
    send_byte(8'h11);
    send_byte(8'h22);
    @(negedge clk);
    tvalid = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    reset = 1'b0;
    stim_words = '{32'h1234_5678};
    run_session(32'd1, 1'b0);
    if (obs_a_addr.size() >= 1) begin
      chk("rst_first_addr", obs_a_addr[0], 32'h0000_0000);
      chk("rst_first_data", obs_a_data[0], 32'h1234_5678);
    end else begin
      chk("rst_write_count", 32'(obs_a_addr.size()), 32'd1);
    end

    // Randomized sessions with gaps, stray start pulses and occasional bad headers.
    stray_start = 1;
    for (int s = 0; s < 25; s++) begin
      gap_pct = $urandom_range(0, 70);
      stim_words.delete();
      n = 32'($urandom_range(1, 6));
      for (int i = 0; i < int'(n); i++) stim_words.push_back($urandom);
      if ($urandom_range(0, 9) == 0) begin
        n = ($urandom_range(0, 1) == 0) ? 32'd0 : 32'(MAXW + 1 + $urandom_range(0, 5000));
        stim_words.delete();
      end
      run_session(n, 1'($urandom_range(0, 3) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
